// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - Control FSM for a memory-backed stack datapath (PUSH/POP/TOP/SUM).
// Optional operand checking is enabled by defining STACK_CTRL_ERRCHK_EN.
module stack_controller #(
    parameter logic [2:0] ALU_ADD = 3'd0,
    parameter logic [2:0] ALU_SUB = 3'd1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rdy,
    input  logic [2:0]  op,
    input  logic        eq,
    input  logic        ge,
    input  logic        hd0,
    input  logic        or_hd,
    output logic [10:0] alpha_k,
    output logic [2:0]  alpha_alu2,
    output logic [2:0]  alpha_alu3,
    output logic [2:0]  alpha_alu4,
    output logic [8:0]  beta,
    output logic        busy
);

    // Operation encodings as latched from the request interface.
    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_TOP  = 3'b010;
    localparam logic [2:0] OP_SUM  = 3'b011;

    // Bit positions inside alpha_k.
    localparam int K1        = 0;
    localparam int K2        = 1;
    localparam int K3        = 2;
    localparam int K4        = 3;
    localparam int K5        = 4;
    localparam int K_IND     = 5;
    localparam int K_I       = 6;
    localparam int K_ESITO   = 7;
    localparam int K_DATAOUT = 8;
    localparam int K_MEM1    = 9;
    localparam int K_MEM2    = 10;

    // Bit positions inside beta.
    localparam int B_HD      = 0;
    localparam int B_IND     = 1;
    localparam int B_I       = 2;
    localparam int B_ESITO   = 3;
    localparam int B_DATAOUT = 5;
    localparam int B_RDYIN   = 6;
    localparam int B_ACKOUT  = 7;
    localparam int B_MEM     = 8;

`ifdef STACK_CTRL_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_SUM_INIT = 3'd2,
        S_SUM_LOOP = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic        err_q;
    logic        req_err;

    // Classify the pending request: invalid ops and an empty SUM always fail,
    // capacity/occupancy checks only when operand checking is built in.
    always_comb begin
        req_err = 1'b0;
        case (op)
            OP_PUSH: req_err = ERRCHK && hd0;
            OP_POP:  req_err = ERRCHK && !or_hd;
            OP_TOP:  req_err = ERRCHK && !or_hd;
            OP_SUM:  req_err = eq || (ERRCHK && !ge);
            default: req_err = 1'b1;
        endcase
    end

    // Sequencer: accept in IDLE, run the op, always finish through DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rdy) begin
                        op_q    <= op;
                        err_q   <= req_err;
                        state_q <= ((op == OP_SUM) && !req_err) ? S_SUM_INIT : S_EXEC;
                    end
                end
                S_EXEC:     state_q <= S_DONE;
                S_SUM_INIT: state_q <= S_SUM_LOOP;
                S_SUM_LOOP: if (eq) state_q <= S_DONE;
                S_DONE:     state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath control decode; SUM_LOOP looks at eq so the final loop cycle writes nothing.
    always_comb begin
        alpha_k    = 11'd0;
        alpha_alu2 = 3'd0;
        alpha_alu3 = 3'd0;
        alpha_alu4 = 3'd0;
        beta       = 9'd0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_EXEC: begin
                if (!err_q) begin
                    case (op_q)
                        OP_PUSH: begin
                            alpha_alu3   = ALU_ADD;
                            beta[B_MEM]  = 1'b1;
                            beta[B_HD]   = 1'b1;
                        end
                        OP_POP: begin
                            alpha_alu3       = ALU_SUB;
                            alpha_k[K_MEM1]  = 1'b1;
                            beta[B_DATAOUT]  = 1'b1;
                            beta[B_HD]       = 1'b1;
                        end
                        OP_TOP: begin
                            alpha_alu3       = ALU_SUB;
                            alpha_k[K_MEM1]  = 1'b1;
                            beta[B_DATAOUT]  = 1'b1;
                        end
                        default: begin
                            alpha_alu3 = 3'd0;
                        end
                    endcase
                end
            end
            S_SUM_INIT: begin
                alpha_k[K5]      = 1'b1;
                alpha_k[K_MEM1]  = 1'b1;
                alpha_alu3       = ALU_SUB;
                alpha_alu4       = ALU_SUB;
                beta[B_IND]      = 1'b1;
                beta[B_I]        = 1'b1;
                beta[B_DATAOUT]  = 1'b1;
            end
            S_SUM_LOOP: begin
                if (!eq) begin
                    alpha_k[K1]        = 1'b1;
                    alpha_k[K3]        = 1'b1;
                    alpha_k[K4]        = 1'b1;
                    alpha_k[K_IND]     = 1'b1;
                    alpha_k[K_I]       = 1'b1;
                    alpha_k[K_DATAOUT] = 1'b1;
                    alpha_k[K_MEM2]    = 1'b1;
                    alpha_alu2         = ALU_ADD;
                    alpha_alu3         = ALU_SUB;
                    alpha_alu4         = ALU_ADD;
                    beta[B_DATAOUT]    = 1'b1;
                    beta[B_IND]        = 1'b1;
                    beta[B_I]          = 1'b1;
                end
            end
            S_DONE: begin
                alpha_k[K_ESITO] = err_q;
                beta[B_ESITO]    = 1'b1;
                beta[B_RDYIN]    = 1'b1;
                beta[B_ACKOUT]   = 1'b1;
            end
            default: begin
                busy = (state_q != S_IDLE);
            end
        endcase
    end

    // K2 is never asserted by any state; keep it explicit for readers of the bit map.
    localparam int K2_UNUSED_POS = K2;

endmodule
